txll_ll: RTL and testbench

Transmit link-layer framer for the SATA port: drains 36-bit frame words that the transmit DMA has written into the TX FIFO and presents them as frames on the TRN transmit interface toward the link/PHY. It sits on the PHY clock between the TX FIFO read port and the link-layer transmit engine. It is the transmit counterpart of the receive link-layer writer.

---
 rtl/txll_ll_if.sv | 31 +++
 rtl/txll_ll.sv | 156 +++++++++++++++
 tb/tb_txll_ll.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/txll_ll_if.sv
// TRN transmit interface between the SATA link-layer framer and the link/PHY engine.
// Ports: master = framer side (drives data/sof/eof/src_rdy/src_dsc); slave = destination side.
interface txll_ll_if;
   logic [31:0] trn_td;
   logic        trn_tsof_n;
   logic        trn_teof_n;
   logic        trn_tsrc_rdy_n;
   logic        trn_tsrc_dsc_n;
   logic        trn_tdst_rdy_n;
   logic        trn_tdst_dsc_n;

   modport master (
      output trn_td,
      output trn_tsof_n,
      output trn_teof_n,
      output trn_tsrc_rdy_n,
      output trn_tsrc_dsc_n,
      input  trn_tdst_rdy_n,
      input  trn_tdst_dsc_n
   );

   modport slave (
      input  trn_td,
      input  trn_tsof_n,
      input  trn_teof_n,
      input  trn_tsrc_rdy_n,
      input  trn_tsrc_dsc_n,
      output trn_tdst_rdy_n,
      output trn_tdst_dsc_n
   );
endinterface

// File: rtl/txll_ll.sv
// SATA transmit link-layer framer: drains FWFT TX FIFO words into TRN frames.
// Ports: phyclk/phyreset (sync, active-high); rd_* FIFO read port; trn master
// interface; txll2port_txcount/done/err status toward the port.
// Option: define TXLL_CUT_THROUGH_EN to start frames as soon as the FIFO is
// non-empty (default is store-and-forward, waiting for rd_eof_rdy).
module txll_ll (
   input  logic             phyclk,
   input  logic             phyreset,
   input  logic [35:0]      rd_do,
   input  logic             rd_empty,
   input  logic             rd_eof_rdy,
   output logic             rd_en,
   txll_ll_if.master        trn,
   output logic [15:0]      txll2port_txcount,
   output logic             txll2port_done,
   output logic             txll2port_err
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SEND  = 2'd1;
   localparam logic [1:0] ST_LAST  = 2'd2;
   localparam logic [1:0] ST_FLUSH = 2'd3;

   logic [1:0]  state;
   logic        oreg_vld;
   logic [31:0] oreg_td;
   logic        oreg_sof_n;
   logic        oreg_eof_n;
   logic        src_dsc_n;
   logic [15:0] txcount;
   logic        done;
   logic        err;

   logic head_sof;
   logic head_eof;
   logic accept;
   logic can_load;
   logic start;
   logic dst_dsc;
   logic abort;
   logic unused_rsvd;

   assign head_sof    = rd_do[32];
   assign head_eof    = rd_do[33];
   assign accept      = oreg_vld & ~trn.trn_tdst_rdy_n;
   assign can_load    = ~rd_empty & (~oreg_vld | accept);

`ifdef TXLL_CUT_THROUGH_EN
   assign start       = ~rd_empty;
   assign unused_rsvd = ^{rd_do[35:34], rd_eof_rdy};
`else
   // eof_rdy implies a non-empty FIFO; the AND keeps rd_en safe anyway
   assign start       = rd_eof_rdy & ~rd_empty;
   assign unused_rsvd = ^rd_do[35:34];
`endif

   assign dst_dsc = ~trn.trn_tdst_dsc_n
                  & ((state == ST_SEND) | (state == ST_LAST));

   // a sof at the head while a load would happen aborts the frame
   assign abort = (state == ST_SEND) & ~dst_dsc & can_load & head_sof;

   always_comb begin
      rd_en = 1'b0;
      if (!phyreset) begin
         case (state)
            ST_IDLE:  rd_en = start;
            ST_SEND:  rd_en = ~dst_dsc & can_load & ~head_sof;
            ST_FLUSH: rd_en = ~rd_empty;
            ST_LAST:  rd_en = 1'b0;
         endcase
      end
   end

   always_ff @(posedge phyclk) begin
      if (phyreset) begin
         state      <= ST_IDLE;
         oreg_vld   <= 1'b0;
         oreg_td    <= 32'd0;
         oreg_sof_n <= 1'b1;
         oreg_eof_n <= 1'b1;
         src_dsc_n  <= 1'b1;
         txcount    <= 16'd0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done      <= 1'b0;
         err       <= 1'b0;
         src_dsc_n <= 1'b1;
         if (accept && txcount != 16'hFFFF)
            txcount <= txcount + 16'd1;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (head_sof) begin
                     oreg_vld   <= 1'b1;
                     oreg_td    <= rd_do[31:0];
                     oreg_sof_n <= 1'b0;
                     oreg_eof_n <= ~head_eof;
                     txcount    <= 16'd0;
                     state      <= head_eof ? ST_LAST : ST_SEND;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ST_SEND: begin
               if (dst_dsc) begin
                  oreg_vld <= 1'b0;
                  err      <= 1'b1;
                  state    <= ST_FLUSH;
               end else if (abort) begin
                  oreg_vld  <= 1'b0;
                  src_dsc_n <= 1'b0;
                  err       <= 1'b1;
                  state     <= ST_IDLE;
               end else if (can_load) begin
                  oreg_vld   <= 1'b1;
                  oreg_td    <= rd_do[31:0];
                  oreg_sof_n <= 1'b1;
                  oreg_eof_n <= ~head_eof;
                  if (head_eof)
                     state <= ST_LAST;
               end else if (accept) begin
                  // underrun: only reachable with cut-through
                  oreg_vld <= 1'b0;
               end
            end
            ST_LAST: begin
               if (dst_dsc) begin
                  oreg_vld <= 1'b0;
                  err      <= 1'b1;
                  state    <= ST_IDLE;
               end else if (accept) begin
                  oreg_vld <= 1'b0;
                  done     <= 1'b1;
                  state    <= ST_IDLE;
               end
            end
            ST_FLUSH: begin
               if (!rd_empty && head_eof)
                  state <= ST_IDLE;
            end
         endcase
      end
   end

   assign trn.trn_td         = oreg_td;
   assign trn.trn_tsof_n     = oreg_sof_n;
   assign trn.trn_teof_n     = oreg_eof_n;
   assign trn.trn_tsrc_rdy_n = ~oreg_vld;
   assign trn.trn_tsrc_dsc_n = src_dsc_n;

   assign txll2port_txcount = txcount;
   assign txll2port_done    = done;
   assign txll2port_err     = err;
endmodule

// File: tb/tb_txll_ll.sv
// Self-checking bench for txll_ll: FWFT FIFO model plus beat scoreboard.
// Ports: drives the FIFO read side and TRN slave side of the framer.
module tb_txll_ll;
   logic        phyclk = 1'b0;
   logic        phyreset = 1'b1;
   logic [35:0] rd_do = '0;
   logic        rd_empty = 1'b1;
   logic        rd_eof_rdy = 1'b0;
   logic        rd_en;
   logic [15:0] txcount;
   logic        done;
   logic        err;

   txll_ll_if trn ();

   txll_ll dut (
      .phyclk            (phyclk),
      .phyreset          (phyreset),
      .rd_do             (rd_do),
      .rd_empty          (rd_empty),
      .rd_eof_rdy        (rd_eof_rdy),
      .rd_en             (rd_en),
      .trn               (trn),
      .txll2port_txcount (txcount),
      .txll2port_done    (done),
      .txll2port_err     (err)
   );

   always #5 phyclk = ~phyclk;

   // FIFO model: stim is written only by the test process
   logic [35:0] stim[$];
   logic [35:0] fifo[$];
   int          stim_rd = 0;
   int          eof_cnt = 0;

   always @(posedge phyclk) begin
      logic [35:0] w;
      if (rd_en && fifo.size() > 0) begin
         w = fifo.pop_front();
         if (w[33]) eof_cnt--;
      end
      while (stim_rd < stim.size()) begin
         w = stim[stim_rd];
         fifo.push_back(w);
         if (w[33]) eof_cnt++;
         stim_rd++;
      end
      rd_empty   <= (fifo.size() == 0);
      rd_do      <= (fifo.size() > 0) ? fifo[0] : 36'd0;
      rd_eof_rdy <= (eof_cnt > 0);
   end

   logic [33:0] sb[$];
   int          checks = 0;
   int          errors = 0;
   int          beats = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          dsc_cnt = 0;
   logic [31:0] last_td = '0;
   logic [31:0] dsc_after = '0;
   logic        last_rd_en = 1'b0;

   task automatic clr_cnt();
      beats = 0;
      done_cnt = 0;
      err_cnt = 0;
      dsc_cnt = 0;
   endtask

   // one clock cycle: observe this cycle, then advance to next negedge
   task automatic cyc();
      logic [33:0] exp;
      logic [33:0] got;
      #1;
      last_rd_en = rd_en;
      if (rd_en) begin
         checks++;
         if (rd_empty) begin
            errors++;
            $display("FAIL pop_empty got rd_en=1 empty=%b need empty=0",
                     rd_empty);
         end
      end
      if (!phyreset && !trn.trn_tsrc_rdy_n && !trn.trn_tdst_rdy_n) begin
         beats++;
         checks++;
         got = {~trn.trn_teof_n, ~trn.trn_tsof_n, trn.trn_td};
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL beat_extra got %h need none", got);
         end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
               errors++;
               $display("FAIL beat got %h need %h", got, exp);
            end
         end
         last_td = trn.trn_td;
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (!trn.trn_tsrc_dsc_n) begin
         dsc_cnt++;
         dsc_after = last_td;
      end
      @(negedge phyclk);
   endtask

   task automatic push_word(input logic sof, input logic eof,
                            input logic [31:0] d, input bit expect_beat);
      logic [35:0] w;
      w = {2'b00, eof, sof, d};
      stim.push_back(w);
      if (expect_beat) sb.push_back(w[33:0]);
   endtask

   task automatic push_frame(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++)
         push_word(i == 0, i == n - 1, base + i, 1'b1);
   endtask

   task automatic wait_beats(input int n, input int budget);
      for (int i = 0; i < budget && beats < n; i++) cyc();
      checks++;
      if (beats < n) begin
         errors++;
         $display("FAIL wait_beats got %0d need %0d", beats, n);
      end
   endtask

   task automatic run_quiet(input int budget);
      int q;
      q = 0;
      for (int i = 0; i < budget && q < 3; i++) begin
         cyc();
         if (fifo.size() == 0 && stim_rd == stim.size()
             && trn.trn_tsrc_rdy_n) q++;
         else q = 0;
      end
      checks++;
      if (q < 3 || sb.size() != 0) begin
         errors++;
         $display("FAIL quiet got pending=%0d fifo=%0d need 0 0",
                  sb.size(), fifo.size());
      end
   endtask

   task automatic chk_status(input string nm, input int d, input int e,
                             input logic [15:0] cnt);
      checks++;
      if (done_cnt != d || err_cnt != e || txcount !== cnt) begin
         errors++;
         $display("FAIL %s got done=%0d err=%0d cnt=%0d need %0d %0d %0d",
                  nm, done_cnt, err_cnt, txcount, d, e, cnt);
      end
   endtask

   task automatic chk_reset_vals(input string nm);
      logic [54:0] got;
      logic [54:0] exp;
      got = {trn.trn_tsrc_rdy_n, trn.trn_tsof_n, trn.trn_teof_n,
             trn.trn_tsrc_dsc_n, trn.trn_td, txcount, done, err, rd_en};
      exp = {4'b1111, 32'd0, 16'd0, 3'b000};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h need %h", nm, got, exp);
      end
   endtask

   task automatic test_reset();
      phyreset = 1'b1;
      trn.trn_tdst_rdy_n = 1'b0;
      trn.trn_tdst_dsc_n = 1'b1;
      repeat (3) cyc();
      chk_reset_vals("reset");
      phyreset = 1'b0;
      repeat (2) cyc();
   endtask

   task automatic test_normal();
      int i;
      clr_cnt();
      push_frame(4, 32'hA000_0000);
      i = 0;
      last_rd_en = 1'b0;
      while (i < 10 && !last_rd_en) begin
         cyc();
         i++;
      end
      checks++;
      if (trn.trn_tsrc_rdy_n !== 1'b0 || trn.trn_tsof_n !== 1'b0
          || trn.trn_td !== 32'hA000_0000) begin
         errors++;
         $display("FAIL first_beat got rdy_n=%b sof_n=%b td=%h need 0 0 a0000000",
                  trn.trn_tsrc_rdy_n, trn.trn_tsof_n, trn.trn_td);
      end
      repeat (4) cyc();
      checks++;
      if (beats != 4) begin
         errors++;
         $display("FAIL back_to_back got %0d beats need 4", beats);
      end
      run_quiet(20);
      chk_status("normal", 1, 0, 16'd4);
   endtask

   task automatic test_backpressure();
      clr_cnt();
      push_frame(4, 32'hB000_0000);
      wait_beats(1, 20);
      trn.trn_tdst_rdy_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (trn.trn_tsrc_rdy_n !== 1'b0 || trn.trn_td !== 32'hB000_0001
             || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL stall got rdy_n=%b td=%h rd_en=%b need 0 b0000001 0",
                     trn.trn_tsrc_rdy_n, trn.trn_td, rd_en);
         end
         cyc();
      end
      trn.trn_tdst_rdy_n = 1'b0;
      run_quiet(20);
      chk_status("backpressure", 1, 0, 16'd4);
   endtask

   task automatic test_dst_dsc();
      clr_cnt();
      for (int i = 0; i < 8; i++)
         push_word(i == 0, i == 7, 32'hC000_0000 + i, i < 2);
      wait_beats(1, 20);
      trn.trn_tdst_dsc_n = 1'b0;
      cyc();
      trn.trn_tdst_dsc_n = 1'b1;
      run_quiet(30);
      chk_status("dst_dsc", 0, 1, 16'd2);
      push_frame(2, 32'hC100_0000);
      run_quiet(20);
      chk_status("after_dsc", 1, 1, 16'd2);
   endtask

   task automatic test_src_abort();
      clr_cnt();
      push_word(1'b0, 1'b0, 32'hD0D0_0000, 1'b0);
      push_word(1'b1, 1'b0, 32'hD000_0000, 1'b1);
      push_word(1'b0, 1'b0, 32'hD000_0001, 1'b1);
      push_word(1'b1, 1'b0, 32'hD100_0000, 1'b1);
      push_word(1'b0, 1'b0, 32'hD100_0001, 1'b1);
      push_word(1'b0, 1'b1, 32'hD100_0002, 1'b1);
      run_quiet(40);
      chk_status("src_abort", 1, 2, 16'd3);
      checks++;
      if (dsc_cnt != 1 || dsc_after !== 32'hD000_0001) begin
         errors++;
         $display("FAIL src_dsc got n=%0d after=%h need 1 d0000001",
                  dsc_cnt, dsc_after);
      end
   endtask

   task automatic test_back_to_back();
      clr_cnt();
      push_frame(2, 32'hE000_0000);
      push_frame(2, 32'hE100_0000);
      run_quiet(30);
      chk_status("two_frames", 2, 0, 16'd2);
   endtask

   task automatic test_reset_mid();
      clr_cnt();
      push_frame(4, 32'hF000_0000);
      wait_beats(2, 20);
      phyreset = 1'b1;
      #1;
      checks++;
      if (rd_en !== 1'b0) begin
         errors++;
         $display("FAIL rd_en_in_reset got %b need 0", rd_en);
      end
      cyc();
      chk_reset_vals("reset_mid");
      sb.delete();
      phyreset = 1'b0;
      run_quiet(20);
      chk_status("reset_drain", 0, 1, 16'd0);
   endtask

   task automatic test_saturation();
      clr_cnt();
      push_frame(70000, 32'h1000_0000);
      wait_beats(1000, 1200);
      checks++;
      if (txcount !== 16'd1000) begin
         errors++;
         $display("FAIL count_track got %0d need 1000", txcount);
      end
      run_quiet(70000);
      chk_status("saturate", 1, 0, 16'hFFFF);
   endtask

   initial begin
      trn.trn_tdst_rdy_n = 1'b0;
      trn.trn_tdst_dsc_n = 1'b1;
      @(negedge phyclk);
      test_reset();
      test_normal();
      test_backpressure();
      test_dst_dsc();
      test_src_abort();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
